// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM states, block size, LANES legality check and GF(2^8) S-box math
package aes_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    localparam int AES_BLOCK_BYTES = 16;

    function automatic bit lanes_ok(input int l);
        return l == 1 || l == 2 || l == 4 || l == 8 || l == 16;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// aes_sbox_lane: one combinational byte substitution, forward or inverse S-box
module aes_sbox_lane
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);

    // inverse table only reachable when it is built in
    always_comb dout = (INV_EN && inv) ? sbox_inv(din) : sbox_fwd(din);

endmodule

// File: rtl/aes_sbox_engine.sv
// aes_sbox_engine: iterative SubBytes/InvSubBytes over a 128-bit state, LANES bytes per cycle
module aes_sbox_engine
    import aes_pkg::*;
#(
    parameter int LANES  = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inverse,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    if (!lanes_ok(LANES)) begin : g_bad_lanes
        $error("aes_sbox_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam int STEPS = AES_BLOCK_BYTES / LANES;
    localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          mode;
    logic [127:0]  data, nxt_data;
    logic          last;
    int            base;
    logic [7:0]    lane_in  [LANES];
    logic [7:0]    lane_out [LANES];

    assign last      = cnt == CW'(STEPS - 1);
    assign base      = LANES * int'(cnt);
    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign busy      = state != ST_IDLE;
    assign out_block = data;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox_lane #(.INV_EN(INV_EN)) u_lane (
            .din  (lane_in[g]),
            .inv  (mode),
            .dout (lane_out[g])
        );
    end

    // pick the LANES bytes addressed by the current step
    always_comb begin
        for (int j = 0; j < LANES; j++) lane_in[j] = data[127-8*(base+j) -: 8];
    end

    // write substituted bytes back in place, rest of the state unchanged
    always_comb begin
        nxt_data = data;
        for (int j = 0; j < LANES; j++) nxt_data[127-8*(base+j) -: 8] = lane_out[j];
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // next state; clear overrides every other transition
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = in_valid  ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_nx = last      ? ST_DONE : ST_BUSY;
            ST_DONE: state_nx = out_ready ? ST_IDLE : ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
        if (clear) state_nx = ST_IDLE;
    end

    // datapath: capture on accept, substitute while busy, step counter wraps on the last step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            mode <= 1'b0;
            data <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (state == ST_IDLE && in_valid) begin
            cnt  <= '0;
            mode <= INV_EN & inverse;
            data <= in_block;
        end else if (state == ST_BUSY) begin
            cnt  <= last ? '0 : cnt + 1'b1;
            data <= nxt_data;
        end
    end

endmodule

// File: tb/tb_aes_sbox_engine.sv
// tb_aes_sbox_engine: four engines (LANES 4/1/16, and LANES 4 forward-only) against a table model
module tb_aes_sbox_engine;

    logic         clk = 1'b0;
    logic         reset_n, clear, in_valid, inverse, out_ready;
    logic [127:0] in_block;
    logic [3:0]   rdy, ov, bz;
    logic [127:0] ob [4];
    int           total = 0;
    int           bad   = 0;
    int           lanes_of [4] = '{4, 1, 16, 4};
    logic [3:0]   inv_en_of = 4'b0111;
    logic [7:0]   fwd_t [256];
    logic [7:0]   inv_t [256];
    logic [2047:0] fwd_hex = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    always #5 clk = ~clk;

    aes_sbox_engine #(.LANES(4), .INV_EN(1'b1)) u_l4 (.clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[0]), .inverse(inverse), .in_block(in_block),
        .out_valid(ov[0]), .out_ready(out_ready), .out_block(ob[0]), .busy(bz[0]));
    aes_sbox_engine #(.LANES(1), .INV_EN(1'b1)) u_l1 (.clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[1]), .inverse(inverse), .in_block(in_block),
        .out_valid(ov[1]), .out_ready(out_ready), .out_block(ob[1]), .busy(bz[1]));
    aes_sbox_engine #(.LANES(16), .INV_EN(1'b1)) u_l16 (.clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[2]), .inverse(inverse), .in_block(in_block),
        .out_valid(ov[2]), .out_ready(out_ready), .out_block(ob[2]), .busy(bz[2]));
    aes_sbox_engine #(.LANES(4), .INV_EN(1'b0)) u_fwd (.clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy[3]), .inverse(inverse), .in_block(in_block),
        .out_valid(ov[3]), .out_ready(out_ready), .out_block(ob[3]), .busy(bz[3]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] b, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv ? inv_t[b[127-8*i -: 8]] : fwd_t[b[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40 && rdy != 4'hf; c++) step();
        check("idle", rdy, 4'hf);
    endtask

    task automatic send(input logic [127:0] blk, input logic inv);
        in_block = blk;
        inverse  = inv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        inverse  = 1'($urandom_range(0, 1));
    endtask

    // called right after the accept edge; gathers latency and result of every engine
    task automatic collect(input logic [127:0] blk, input logic inv, output logic [127:0] got [4]);
        logic [3:0] seen = 4'h0;
        int         lat [4] = '{0, 0, 0, 0};
        for (int c = 1; c <= 24 && seen != 4'hf; c++) begin
            in_block = rnd128();
            step();
            for (int d = 0; d < 4; d++)
                if (!seen[d] && ov[d]) begin
                    seen[d] = 1'b1;
                    lat[d]  = c;
                    got[d]  = ob[d];
                end
        end
        for (int d = 0; d < 4; d++) begin
            check($sformatf("lat%0d", d), 128'(lat[d]), 128'(16 / lanes_of[d]));
            check($sformatf("data%0d", d), got[d], model(blk, inv & inv_en_of[d]));
        end
    endtask

    task automatic run(input logic [127:0] blk, input logic inv, output logic [127:0] got [4]);
        wait_idle();
        send(blk, inv);
        collect(blk, inv, got);
    endtask

    task automatic quiet(input string tag);
        logic [3:0] seen = 4'h0;
        for (int c = 0; c < 20; c++) begin
            step();
            seen = seen | ov;
        end
        check(tag, seen, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] got [4];
        logic [127:0] b1, b2, snap;
        logic         inv;
        for (int i = 0; i < 256; i++) fwd_t[i] = fwd_hex[2047-8*i -: 8];
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; inverse = 1'b0; out_ready = 1'b1;
        in_block = '0;
        step();
        check("rst_ready", rdy, 4'hf);
        check("rst_valid", ov, 4'h0);
        check("rst_busy", bz, 4'h0);
        check("rst_data", ob[0], '0);
        reset_n = 1'b1;
        step();
        check("post_rst_ready", rdy, 4'hf);

        run('0, 1'b0, got);
        check("zero_fwd", got[0], {16{8'h63}});
        run(128'h00112233445566778899aabbccddeeff, 1'b0, got);
        check("l1_fwd", got[1], 128'h638293c31bfc33f5c4eeacea4bc12816);
        run(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, got);
        check("l16_inv", got[2], 128'h00112233445566778899aabbccddeeff);
        for (int t = 0; t < 20; t++) run(rnd128(), 1'($urandom_range(0, 1)), got);

        wait_idle();
        b1 = rnd128();
        b2 = rnd128();
        inv = 1'b1;
        out_ready = 1'b0;
        in_block = b1;
        inverse = inv;
        in_valid = 1'b1;
        step();
        in_block = b2;
        for (int c = 0; c < 30 && ov != 4'hf; c++) step();
        check("bp_done", ov, 4'hf);
        snap = ob[0];
        check("bp_data", snap, model(b1, inv));
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_hold", ob[0], snap);
            check("bp_noready", rdy, 4'h0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release", rdy, 4'hf);
        check("bp_release_busy", bz, 4'h0);
        step();
        in_valid = 1'b0;
        check("bp_accept", bz, 4'hf);
        collect(b2, inv, got);

        wait_idle();
        in_block = rnd128();
        in_valid = 1'b1;
        clear = 1'b1;
        step();
        check("clr_prio", rdy, 4'hf);
        clear = 1'b0;
        in_valid = 1'b0;
        send(rnd128(), 1'b0);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_ready", rdy, 4'hf);
        check("clr_valid", ov, 4'h0);
        quiet("clr_quiet");
        run(rnd128(), 1'b1, got);

        wait_idle();
        send(rnd128(), 1'b1);
        step();
        reset_n = 1'b0;
        #1;
        check("arst_ready", rdy, 4'hf);
        check("arst_valid", ov, 4'h0);
        check("arst_busy", bz, 4'h0);
        check("arst_data", ob[0], '0);
        step();
        reset_n = 1'b1;
        quiet("arst_quiet");
        run(rnd128(), 1'b0, got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
